// File: rtl/jk_edge_monitor.sv
// Watches the complementary outputs of an upstream JK flip-flop. It counts rising and
// falling edges, measures high-period length, and latches a sticky error on invalid pairs.
module jk_edge_monitor #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          q,
   input  logic          qb,
   input  logic          clear,
   output logic          rise,
   output logic          fall,
   output logic [CW-1:0] rise_cnt,
   output logic [CW-1:0] fall_cnt,
   output logic [CW-1:0] hi_len,
   output logic          err,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      S_UNKNOWN = 2'd0,
      S_LOW     = 2'd1,
      S_HIGH    = 2'd2,
      S_FAULT   = 2'd3
   } state_t;

   state_t        state_r, state_nxt;
   logic          rise_nxt, fall_nxt, err_nxt;
   logic [CW-1:0] rise_cnt_nxt, fall_cnt_nxt, hi_len_nxt;
   logic [CW-1:0] run, run_nxt;
   logic          invalid;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   assign invalid = (q == qb);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_nxt    = state_r;
      rise_nxt     = 1'b0;
      fall_nxt     = 1'b0;
      rise_cnt_nxt = rise_cnt;
      fall_cnt_nxt = fall_cnt;
      hi_len_nxt   = hi_len;
      run_nxt      = run;
      err_nxt      = err;

      if (invalid) begin
         state_nxt = S_FAULT;
      end else begin
         case (state_r)
            S_LOW: begin
               if (q) begin
                  state_nxt    = S_HIGH;
                  rise_nxt     = 1'b1;
                  rise_cnt_nxt = sat_inc(rise_cnt);
                  run_nxt      = CW'(1);
               end
            end
            S_HIGH: begin
               if (!q) begin
                  state_nxt    = S_LOW;
                  fall_nxt     = 1'b1;
                  fall_cnt_nxt = sat_inc(fall_cnt);
                  hi_len_nxt   = run;
               end else begin
                  run_nxt = sat_inc(run);
               end
            end
            default: begin
               // Leaving UNKNOWN or FAULT only re-establishes the level; no edge is counted.
               state_nxt = q ? S_HIGH : S_LOW;
               if (q) run_nxt = CW'(1);
            end
         endcase
      end

      // Clear zeroes the counters and err, but an invalid sample on the same edge still sets err.
      if (clear) begin
         rise_cnt_nxt = '0;
         fall_cnt_nxt = '0;
         hi_len_nxt   = '0;
         err_nxt      = 1'b0;
      end
      if (invalid) err_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all of them update together.
      if (reset) begin
         state_r  <= S_UNKNOWN;
         rise     <= 1'b0;
         fall     <= 1'b0;
         rise_cnt <= '0;
         fall_cnt <= '0;
         hi_len   <= '0;
         run      <= '0;
         err      <= 1'b0;
      end else begin
         state_r  <= state_nxt;
         rise     <= rise_nxt;
         fall     <= fall_nxt;
         rise_cnt <= rise_cnt_nxt;
         fall_cnt <= fall_cnt_nxt;
         hi_len   <= hi_len_nxt;
         run      <= run_nxt;
         err      <= err_nxt;
      end
   end

   assign state = state_r;

endmodule
